// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - per-channel synchronizer, debouncer and press/release edge detector
module input_conditioner #(
  parameter int width_p           = 3,
  parameter int sync_depth_p      = 2,
  parameter int debounce_cycles_p = 250000,
  parameter int active_low_p      = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] raw_i,
  output logic [width_p-1:0] level_o,
  output logic [width_p-1:0] press_o,
  output logic [width_p-1:0] release_o
);

  // Refuse to build with parameter values the datapath cannot honour.
  if (width_p < 1 || sync_depth_p < 2 || debounce_cycles_p < 1 ||
      (active_low_p != 0 && active_low_p != 1)) begin : g_bad_param
    $error("input_conditioner: illegal parameter value");
  end

  localparam int cnt_w_p = $clog2(debounce_cycles_p + 1);
  localparam logic [cnt_w_p-1:0] cnt_last_p = cnt_w_p'(debounce_cycles_p - 1);
  // Raw level meaning "not asserted"; XOR with it also normalises polarity.
  localparam logic [width_p-1:0] inactive_p =
    (active_low_p != 0) ? {width_p{1'b1}} : {width_p{1'b0}};

  logic [sync_depth_p-1:0][width_p-1:0] sync_q;
  logic [width_p-1:0]                   norm;

  // Plain flop chain per channel; reset parks it at the inactive raw level.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= {sync_depth_p{inactive_p}};
    end else begin
      sync_q <= {sync_q[sync_depth_p-2:0], raw_i};
    end
  end

  assign norm = sync_q[sync_depth_p-1] ^ inactive_p;

  for (genvar i = 0; i < width_p; i++) begin : g_ch
    logic               stable_q;
    logic               press_q;
    logic               release_q;
    logic [cnt_w_p-1:0] cnt_q;

    // Count consecutive disagreeing cycles; commit and pulse on the last one.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        stable_q  <= 1'b0;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else if (norm[i] == stable_q) begin
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else if (cnt_q == cnt_last_p) begin
        stable_q  <= norm[i];
        cnt_q     <= '0;
        press_q   <= norm[i];
        release_q <= ~norm[i];
      end else begin
        cnt_q     <= cnt_q + cnt_w_p'(1);
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end
    end

    assign level_o[i]   = stable_q;
    assign press_o[i]   = press_q;
    assign release_o[i] = release_q;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - table, directed and random checks of input_conditioner
module tb_input_conditioner;

  localparam int W = 3;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] raw = '0;
  logic [W-1:0] raw_al;
  logic [W-1:0] level, press, rel;
  logic [W-1:0] level_al, press_al, rel_al;

  assign raw_al = ~raw;

  always #5 clk = ~clk;

  input_conditioner #(.width_p(W), .sync_depth_p(S), .debounce_cycles_p(D), .active_low_p(0)) dut (
    .clk_i(clk), .reset_i(reset), .raw_i(raw),
    .level_o(level), .press_o(press), .release_o(rel)
  );

  input_conditioner #(.width_p(W), .sync_depth_p(S), .debounce_cycles_p(D), .active_low_p(1)) dut_al (
    .clk_i(clk), .reset_i(reset), .raw_i(raw_al),
    .level_o(level_al), .press_o(press_al), .release_o(rel_al)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a channel's level flips once the last D synchronised
  // samples all disagree with it; samples reach the debouncer S edges late.
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] norm_hist[$];
  logic [W-1:0] m_level = '0, m_press = '0, m_rel = '0;

  task automatic model_edge(input logic r, input logic [W-1:0] v);
    logic [W-1:0] n;
    bit flip;
    if (r) begin
      foreach (raw_hist[k]) raw_hist[k] = '0;
      foreach (norm_hist[k]) norm_hist[k] = '0;
      m_level = '0; m_press = '0; m_rel = '0;
    end else begin
      n = raw_hist[raw_hist.size() - S];
      raw_hist.push_back(v);
      norm_hist.push_back(n);
      m_press = '0; m_rel = '0;
      for (int ch = 0; ch < W; ch++) begin
        flip = 1'b1;
        for (int k = 0; k < D; k++)
          if (norm_hist[norm_hist.size() - 1 - k][ch] == m_level[ch]) flip = 1'b0;
        if (flip) begin
          m_level[ch] = ~m_level[ch];
          if (m_level[ch]) m_press[ch] = 1'b1;
          else             m_rel[ch]   = 1'b1;
        end
      end
      while (raw_hist.size() > S + 2) void'(raw_hist.pop_front());
      while (norm_hist.size() > D + 2) void'(norm_hist.pop_front());
    end
  endtask

  task automatic apply(input logic r, input logic [W-1:0] v);
    reset = r;
    raw = v;
    @(posedge clk);
    model_edge(r, v);
    #1;
  endtask

  task automatic step(input logic r, input logic [W-1:0] v);
    apply(r, v);
    chk("level", level, m_level);
    chk("press", press, m_press);
    chk("release", rel, m_rel);
    chk("level_al", level_al, m_level);
    chk("press_al", press_al, m_press);
    chk("release_al", rel_al, m_rel);
    chk("press_and_release", press & rel, '0);
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] raw;
    logic [W-1:0] lvl;
    logic [W-1:0] prs;
    logic [W-1:0] rls;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int cnt_p, cnt_r, idx;
    logic [W-1:0] v;
    int len;
    logic r;

    for (int k = 0; k < S + 2; k++) raw_hist.push_back('0);
    for (int k = 0; k < D + 2; k++) norm_hist.push_back('0);

    // Reset, a channel-0 press after S+D edges, then its release.
    tbl[0] = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[1] = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000};
    for (int k = 2; k <= 6; k++) tbl[k] = '{1'b0, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[7] = '{1'b0, 3'b001, 3'b001, 3'b001, 3'b000};
    tbl[8] = '{1'b0, 3'b001, 3'b001, 3'b000, 3'b000};
    tbl[9] = '{1'b0, 3'b001, 3'b001, 3'b000, 3'b000};
    for (int k = 10; k <= 14; k++) tbl[k] = '{1'b0, 3'b000, 3'b001, 3'b000, 3'b000};
    tbl[15] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b001};
    tbl[16] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000};

    for (int k = 0; k < 17; k++) begin
      apply(tbl[k].rst, tbl[k].raw);
      chk($sformatf("tbl%0d_level", k), level, tbl[k].lvl);
      chk($sformatf("tbl%0d_press", k), press, tbl[k].prs);
      chk($sformatf("tbl%0d_release", k), rel, tbl[k].rls);
      chk($sformatf("tbl%0d_level_al", k), level_al, tbl[k].lvl);
    end

    // Three-cycle glitch must not commit.
    cnt_p = 0;
    for (int k = 0; k < 3; k++) begin step(1'b0, 3'b001); cnt_p += int'(press[0]); end
    for (int k = 0; k < 8; k++) begin step(1'b0, 3'b000); cnt_p += int'(press[0]); end
    chk("glitch_press_count", cnt_p, 0);
    chk("glitch_level", level[0], 1'b0);

    // Channel 1 toggling every two cycles, then held high: one late press.
    cnt_p = 0; idx = -1;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, ((k / 2) % 2 == 0) ? 3'b010 : 3'b000);
      cnt_p += int'(press[1]);
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 3'b010);
      if (press[1]) begin cnt_p++; idx = k; end
    end
    chk("toggle_press_count", cnt_p, 1);
    chk("toggle_press_edge", idx, 5);

    // From level 100, switch to 010: press and release on the same edge.
    for (int k = 0; k < 8; k++) step(1'b0, 3'b100);
    chk("pre_swap_level", level, 3'b100);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 3'b010);
      if (k == 5) begin
        chk("swap_press", press, 3'b010);
        chk("swap_release", rel, 3'b100);
      end
    end

    // Reset mid-count discards the count; active-low sees raw 111 as idle.
    step(1'b1, 3'b000);
    step(1'b1, 3'b000);
    for (int k = 0; k < 5; k++) step(1'b0, 3'b001);
    step(1'b1, 3'b001);
    cnt_p = 0; cnt_r = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 3'b000);
      cnt_p += $countones(press);
      cnt_r += $countones(rel);
    end
    chk("midreset_press_count", cnt_p, 0);
    chk("midreset_release_count", cnt_r, 0);
    chk("midreset_level", level, 3'b000);
    chk("active_low_idle_level", level_al, 3'b000);
    chk("active_low_idle_press", press_al, 3'b000);

    // Inputs held active through reset release.
    for (int k = 0; k < 3; k++) step(1'b1, 3'b111);
    cnt_r = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 3'b111);
      cnt_r += $countones(rel);
      if (k == 5) chk("held_reset_press", press, 3'b111);
    end
    chk("held_reset_release_count", cnt_r, 0);

    // Random bursts of held values with occasional resets.
    for (int b = 0; b < 60; b++) begin
      v = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 8);
      r = ($urandom_range(0, 29) == 0);
      for (int k = 0; k < len; k++) step(r && (k == 0), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
